// File: rtl/rename_freelist.sv
// Free list of physical destination registers for the rename stage.
// A circular FIFO of preg indices with compacted multi-pop (rename) and multi-push (commit).
module rename_freelist #(
   parameter int FRONTEND_WIDTH      = 2,
   parameter int COMMIT_WIDTH        = 2,
   parameter int NB_PHYS_REGS        = 64,
   parameter int PHYS_REGS_ADDR_SIZE = 6,
   localparam int DEPTH              = NB_PHYS_REGS - 32,
   localparam int PTR_W              = $clog2(DEPTH)
) (
   input  logic                                          clk,
   input  logic                                          reset_n,
   input  logic [FRONTEND_WIDTH-1:0]                     rename_alloc_v_i,
   output logic [FRONTEND_WIDTH*PHYS_REGS_ADDR_SIZE-1:0] freelist_preg_o,
   output logic                                          freelist_stall_o,
   input  logic [COMMIT_WIDTH-1:0]                       commit_free_v_i,
   input  logic [COMMIT_WIDTH*PHYS_REGS_ADDR_SIZE-1:0]   commit_free_preg_i,
   output logic [PTR_W:0]                                freelist_count_o,
   output logic                                          freelist_empty_o,
   output logic                                          freelist_err_o
);

   localparam int PRW = PHYS_REGS_ADDR_SIZE;
   localparam int CW  = PTR_W + 2;

   logic [PRW-1:0]   entry_q [DEPTH];
   logic [PRW-1:0]   entry_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             empty_q, empty_d;
   logic             err_q, err_d;

   logic [CW-1:0]           req_n, pop_n, push_n, accept_n, room;
   logic                    stall;
   logic [CW-1:0]           alloc_off [FRONTEND_WIDTH];
   logic [CW-1:0]           push_off  [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0] push_v;
   logic [PTR_W-1:0]        wr_idx;

   // Allocation is all-or-nothing: a partial grant would split a rename bundle.
   always_comb begin
      req_n = '0;
      for (int i = 0; i < FRONTEND_WIDTH; i++) begin
         alloc_off[i] = req_n;
         req_n        = req_n + CW'(rename_alloc_v_i[i]);
      end
      stall = req_n > CW'(count_q);
      pop_n = stall ? '0 : req_n;
   end

   for (genvar gi = 0; gi < FRONTEND_WIDTH; gi++) begin : g_grant
      logic [PTR_W-1:0] rd_idx;
      assign rd_idx = PTR_W'(CW'(head_q) + alloc_off[gi]);
      assign freelist_preg_o[gi*PRW +: PRW] =
         (rename_alloc_v_i[gi] && !stall) ? entry_q[rd_idx] : '0;
   end

   // p0 is hard-wired zero in the register file, so releasing it is a no-op.
   always_comb begin
      push_n = '0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         push_v[j]   = commit_free_v_i[j] && (commit_free_preg_i[j*PRW +: PRW] != '0);
         push_off[j] = push_n;
         push_n      = push_n + CW'(push_v[j]);
      end
      room     = CW'(DEPTH) - CW'(count_q) + pop_n;
      accept_n = (push_n > room) ? room : push_n;
   end

   always_comb begin
      entry_d = entry_q;
      wr_idx  = '0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         wr_idx = PTR_W'(CW'(tail_q) + push_off[j]);
         if (push_v[j] && (push_off[j] < room)) begin
            entry_d[wr_idx] = commit_free_preg_i[j*PRW +: PRW];
         end
      end
      head_d  = PTR_W'(CW'(head_q) + pop_n);
      tail_d  = PTR_W'(CW'(tail_q) + accept_n);
      count_d = (PTR_W+1)'(CW'(count_q) - pop_n + accept_n);
      empty_d = (count_d == '0);
      err_d   = err_q | (push_n > room);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            entry_q[k] <= PRW'(32 + k);
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= (PTR_W+1)'(DEPTH);
         empty_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         entry_q <= entry_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         empty_q <= empty_d;
         err_q   <= err_d;
      end
   end

   assign freelist_stall_o = stall;
   assign freelist_count_o = count_q;
   assign freelist_empty_o = empty_q;
   assign freelist_err_o   = err_q;

endmodule
